// File: rtl/agen_lsu_pipe_pkg.sv
// Shared types and helpers for the AGEN-to-LSU pipeline: default widths, the
// memory packet layout and the branch-mask kill check.
package agen_lsu_pipe_pkg;

  localparam int unsigned PKT_W_DEF  = 128;
  localparam int unsigned MASK_W_DEF = 8;
  // Widest branch mask the kill check supports; narrower masks are zero-extended.
  localparam int unsigned MASK_W_MAX = 64;

  typedef struct packed {
    logic [47:0] vaddr;
    logic [63:0] wdata;
    logic [7:0]  byte_en;
    logic [3:0]  op;
    logic [1:0]  size;
    logic        is_store;
    logic        sign_ext;
  } mem_pkt_t;

  function automatic logic [PKT_W_DEF-1:0] pack_mem_pkt(input mem_pkt_t p);
    return p;
  endfunction

  function automatic mem_pkt_t unpack_mem_pkt(input logic [PKT_W_DEF-1:0] flat);
    return mem_pkt_t'(flat);
  endfunction

  function automatic logic is_killed(input logic [MASK_W_MAX-1:0] mask,
                                     input logic                  squash,
                                     input logic [MASK_W_MAX-1:0] squash_mask);
    return squash & (|(mask & squash_mask));
  endfunction

endpackage

// File: rtl/agen_lsu_pipe_slot.sv
// One pipeline slot: valid, payload and branch mask with load/leave/kill/clear
// and flush handling. Exposes its next-state valid for occupancy counting.
module agen_lsu_pipe_slot
  import agen_lsu_pipe_pkg::*;
#(
  parameter int unsigned PKT_W  = PKT_W_DEF,
  parameter int unsigned MASK_W = MASK_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              load_kill_i,
  input  logic              leave_i,
  input  logic              kill_i,
  input  logic [MASK_W-1:0] clear_mask_i,
  input  logic [PKT_W-1:0]  pkt_i,
  input  logic [MASK_W-1:0] mask_i,
  output logic              valid_o,
  output logic              valid_d_o,
  output logic [PKT_W-1:0]  pkt_o,
  output logic [MASK_W-1:0] mask_o
);

  logic              valid_q, valid_d;
  logic [PKT_W-1:0]  pkt_q, pkt_d;
  logic [MASK_W-1:0] mask_q, mask_d;

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    mask_d  = mask_q & ~clear_mask_i;
    if (flush_i) begin
      valid_d = 1'b0;
      pkt_d   = '0;
      mask_d  = '0;
    end else if (load_i) begin
      // A killed op is still consumed from upstream but lands invalid.
      valid_d = ~load_kill_i;
      pkt_d   = pkt_i;
      mask_d  = mask_i & ~clear_mask_i;
    end else if (leave_i || kill_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
      mask_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      mask_q  <= mask_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign pkt_o     = pkt_q;
  assign mask_o    = mask_q;

endmodule

// File: rtl/agen_lsu_pipe.sv
// Back-pressured AGEN-to-LSU pipeline of STAGES slots with bubble collapsing,
// full flush, branch-mask squash and resolved-branch mask clearing.
module agen_lsu_pipe
  import agen_lsu_pipe_pkg::*;
#(
  parameter int unsigned PKT_W  = PKT_W_DEF,
  parameter int unsigned STAGES = 2,
  parameter int unsigned MASK_W = MASK_W_DEF,
  parameter int unsigned OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PKT_W-1:0]  in_pkt_i,
  input  logic [MASK_W-1:0] in_mask_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PKT_W-1:0]  out_pkt_o,
  output logic [MASK_W-1:0] out_mask_o,
  input  logic              squash_i,
  input  logic [MASK_W-1:0] squash_mask_i,
  input  logic [MASK_W-1:0] clear_mask_i,
  output logic [OCC_W-1:0]  occupancy_o
);

  localparam int unsigned Last = STAGES - 1;

  logic [STAGES-1:0] slot_valid;
  logic [STAGES-1:0] slot_valid_d;
  logic [STAGES-1:0] killed;
  logic [STAGES-1:0] go;
  logic [PKT_W-1:0]  slot_pkt  [STAGES];
  logic [MASK_W-1:0] slot_mask [STAGES];
  logic              in_kill;
  logic              accept;
  logic [OCC_W-1:0]  occ_q, occ_d;

  always_comb begin
    killed = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      killed[s] = is_killed(MASK_W_MAX'(slot_mask[s]), squash_i, MASK_W_MAX'(squash_mask_i));
    end
  end

  assign in_kill = is_killed(MASK_W_MAX'(in_mask_i), squash_i, MASK_W_MAX'(squash_mask_i));

  // Walk from the head toward the entry so the chain never reads its own output.
  always_comb begin
    logic nxt_go;
    go       = '0;
    nxt_go   = slot_valid[Last] & (out_ready_i | killed[Last]);
    go[Last] = nxt_go;
    for (int s = int'(STAGES) - 2; s >= 0; s--) begin
      nxt_go = slot_valid[s] & (~slot_valid[s+1] | nxt_go);
      go[s]  = nxt_go;
    end
  end

  assign in_ready_o = ~flush_i & (~slot_valid[0] | go[0]);
  assign accept     = in_valid_i & in_ready_o;

  for (genvar s = 0; s < STAGES; s++) begin : g_slot
    logic              load, load_kill;
    logic [PKT_W-1:0]  pkt_in;
    logic [MASK_W-1:0] mask_in;

    if (s == 0) begin : g_entry
      assign load      = accept;
      assign load_kill = in_kill;
      assign pkt_in    = in_pkt_i;
      assign mask_in   = in_mask_i;
    end else begin : g_chain
      assign load      = go[s-1];
      assign load_kill = killed[s-1];
      assign pkt_in    = slot_pkt[s-1];
      assign mask_in   = slot_mask[s-1];
    end

    agen_lsu_pipe_slot #(
      .PKT_W  (PKT_W),
      .MASK_W (MASK_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (flush_i),
      .load_i       (load),
      .load_kill_i  (load_kill),
      .leave_i      (go[s]),
      .kill_i       (killed[s]),
      .clear_mask_i (clear_mask_i),
      .pkt_i        (pkt_in),
      .mask_i       (mask_in),
      .valid_o      (slot_valid[s]),
      .valid_d_o    (slot_valid_d[s]),
      .pkt_o        (slot_pkt[s]),
      .mask_o       (slot_mask[s])
    );
  end

  always_comb begin
    occ_d = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      occ_d = occ_d + OCC_W'(slot_valid_d[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Flush overrides any head handshake in the same cycle.
  assign out_valid_o = slot_valid[Last] & ~killed[Last] & ~flush_i;
  assign out_pkt_o   = slot_pkt[Last];
  assign out_mask_o  = slot_mask[Last] & ~clear_mask_i;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_agen_lsu_pipe.sv
// Directed, table-driven bench for agen_lsu_pipe with STAGES=3.
module tb_agen_lsu_pipe;

  localparam int unsigned PktW   = 128;
  localparam int unsigned Stages = 3;
  localparam int unsigned MaskW  = 8;
  localparam int unsigned OccW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PktW-1:0]   in_pkt_i;
  logic [MaskW-1:0]  in_mask_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PktW-1:0]   out_pkt_o;
  logic [MaskW-1:0]  out_mask_o;
  logic              squash_i;
  logic [MaskW-1:0]  squash_mask_i;
  logic [MaskW-1:0]  clear_mask_i;
  logic [OccW-1:0]   occupancy_o;

  always #5 clk = ~clk;

  agen_lsu_pipe #(
    .PKT_W  (PktW),
    .STAGES (Stages),
    .MASK_W (MaskW),
    .OCC_W  (OccW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_pkt_i      (in_pkt_i),
    .in_mask_i     (in_mask_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pkt_o     (out_pkt_o),
    .out_mask_o    (out_mask_o),
    .squash_i      (squash_i),
    .squash_mask_i (squash_mask_i),
    .clear_mask_i  (clear_mask_i),
    .occupancy_o   (occupancy_o)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [15:0] ip;
    logic [7:0]  im;
    logic        ordy;
    logic        sq;
    logic [7:0]  sm;
    logic [7:0]  cm;
    logic        e_rdy;
    logic        e_vld;
    logic        chk_pkt;
    logic [15:0] e_pkt;
    logic [7:0]  e_mask;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                              input logic [15:0] ip, input logic [7:0] im,
                              input logic ordy, input logic sq, input logic [7:0] sm,
                              input logic [7:0] cm, input logic e_rdy, input logic e_vld,
                              input logic chk_pkt, input logic [15:0] e_pkt,
                              input logic [7:0] e_mask, input logic [1:0] e_occ);
    vec_t v;
    v = '{rst, flush, iv, ip, im, ordy, sq, sm, cm, e_rdy, e_vld, chk_pkt, e_pkt, e_mask, e_occ};
    return v;
  endfunction

  function automatic logic [PktW-1:0] wide(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic drive(input vec_t v);
    reset         = v.rst;
    flush_i       = v.flush;
    in_valid_i    = v.iv;
    in_pkt_i      = wide(v.ip);
    in_mask_i     = v.im;
    out_ready_i   = v.ordy;
    squash_i      = v.sq;
    squash_mask_i = v.sm;
    clear_mask_i  = v.cm;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    checks++;
    ok = (in_ready_o === v.e_rdy) && (out_valid_o === v.e_vld) && (occupancy_o === v.e_occ);
    if (v.chk_pkt) ok = ok && (out_pkt_o === wide(v.e_pkt)) && (out_mask_o === v.e_mask);
    if (!ok) begin
      errors++;
      $display("FAIL vec%0d: got rdy=%0b vld=%0b occ=%0d pkt=%0h mask=%0h; want rdy=%0b vld=%0b occ=%0d pkt=%0h mask=%0h (pkt checked=%0b)",
               idx, in_ready_o, out_valid_o, occupancy_o, out_pkt_o, out_mask_o,
               v.e_rdy, v.e_vld, v.e_occ, wide(v.e_pkt), v.e_mask, v.chk_pkt);
    end
  endtask

  task automatic check_val(input string name, input logic [PktW-1:0] got,
                           input logic [PktW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    int lat;

    // Streaming 1..8 with out_ready held high.
    vecs.push_back(mk(0,0,1,16'h1,0,1,0,0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,16'h2,0,1,0,0,0, 1,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,16'h3,0,1,0,0,0, 1,0,0,0,0,2));
    vecs.push_back(mk(0,0,1,16'h4,0,1,0,0,0, 1,1,1,16'h1,0,3));
    vecs.push_back(mk(0,0,1,16'h5,0,1,0,0,0, 1,1,1,16'h2,0,3));
    vecs.push_back(mk(0,0,1,16'h6,0,1,0,0,0, 1,1,1,16'h3,0,3));
    vecs.push_back(mk(0,0,1,16'h7,0,1,0,0,0, 1,1,1,16'h4,0,3));
    vecs.push_back(mk(0,0,1,16'h8,0,1,0,0,0, 1,1,1,16'h5,0,3));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,     1,1,1,16'h6,0,3));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,     1,1,1,16'h7,0,2));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,     1,1,1,16'h8,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,     1,0,0,0,0,0));
    // Fill with out_ready low, then single-cycle release.
    vecs.push_back(mk(0,0,1,16'h11,0,0,0,0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,16'h12,0,0,0,0,0, 1,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,16'h13,0,0,0,0,0, 1,0,0,0,0,2));
    vecs.push_back(mk(0,0,1,16'h14,0,0,0,0,0, 0,1,1,16'h11,0,3));
    vecs.push_back(mk(0,0,1,16'h14,0,1,0,0,0, 1,1,1,16'h11,0,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      0,1,1,16'h12,0,3));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,      1,1,1,16'h12,0,3));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,      1,1,1,16'h13,0,2));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,      1,1,1,16'h14,0,1));
    // Masks 0x01,0x02,0x01 then squash 0x01.
    vecs.push_back(mk(0,0,1,16'h21,8'h01,0,0,0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,16'h22,8'h02,0,0,0,0, 1,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,16'h23,8'h01,0,0,0,0, 1,0,0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,0,1,8'h01,0,      1,0,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,          1,1,1,16'h22,8'h02,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,          1,1,1,16'h22,8'h02,1));
    // Clear 0x04 on mask 0x06, later squash 0x04 kills nothing.
    vecs.push_back(mk(0,0,1,16'h31,8'h06,0,0,0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,8'h04,      1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,          1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,1,8'h04,0,      1,1,1,16'h31,8'h02,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,8'h02,      1,1,1,16'h31,8'h00,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,          1,1,1,16'h31,8'h00,1));
    // Flush while full with out_ready high.
    vecs.push_back(mk(0,0,1,16'h41,0,0,0,0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,16'h42,0,0,0,0,0, 1,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,16'h43,0,0,0,0,0, 1,0,0,0,0,2));
    vecs.push_back(mk(0,1,1,16'h44,0,1,0,0,0, 0,0,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      1,0,1,0,0,0));
    // Reset mid-stream with a valid input.
    vecs.push_back(mk(0,0,1,16'h51,0,0,0,0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,1,16'h52,0,0,0,0,0, 1,0,0,0,0,1));
    vecs.push_back(mk(1,0,1,16'h53,0,0,0,0,0, 1,0,0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,      1,0,1,0,0,0));

    drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("reset_out_valid", PktW'(out_valid_o), '0);
    check_val("reset_occ", PktW'(occupancy_o), '0);
    check_val("reset_in_ready", PktW'(in_ready_o), PktW'(1));
    check_val("reset_out_pkt", out_pkt_o, '0);
    check_val("reset_out_mask", PktW'(out_mask_o), '0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Accept-to-handoff latency on an empty pipe.
    @(negedge clk);
    drive(mk(0,0,1,16'h61,0,1,0,0,0, 0,0,0,0,0,0));
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid_i = 1'b0;
      #1;
      if (out_valid_o) break;
    end
    check_val("latency", PktW'(lat), PktW'(Stages));
    check_val("latency_pkt", out_pkt_o, wide(16'h61));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
